// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   It lights one digit per refresh slot and decodes hex 0-F. It supports
//   per-digit enables, decimal points and optional leading-zero blanking.
//   Display data is double-buffered, so a load only takes effect at a frame
//   boundary.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   load       one-cycle strobe; captures value / dp_in / digit_en
//   value      hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in      decimal point request per digit (1 = lit)
//   digit_en   per-digit enable (0 = digit dark)
//   lz_en      leading-zero blanking enable (live, not buffered)
//   an         anode selects, active-low
//   a2g        segments {a,b,c,d,e,f,g}, active-low
//   dp         decimal point segment, active-low
//   frame_tick one-cycle pulse with the first output of each new frame
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              a2g,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int VW = 4 * NUM_DIGITS;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  wrap;
  logic                  wrap_q;

  logic [VW-1:0]         act_val, pend_val;
  logic [NUM_DIGITS-1:0] act_dp, pend_dp;
  logic [NUM_DIGITS-1:0] act_en, pend_en;
  logic                  pend_valid;

  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            a2g_next;
  logic                  dp_next;
  logic [3:0]            nibble;
  logic [VW-1:0]         upper;
  logic                  lz_blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0000100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  // The frame ends on the last cycle of the last digit's slot.
  assign wrap = (cnt == CW'(REFRESH_DIV - 1)) && (idx == IW'(NUM_DIGITS - 1));

  // Divider and scan index
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      idx    <= '0;
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap;
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Double buffer. A load that coincides with a wrap goes straight to the
  // active buffer, so it cannot be lost behind a stale pending copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_val    <= '0;
      act_dp     <= '0;
      act_en     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_en    <= '0;
      pend_valid <= 1'b0;
    end else if (load && wrap) begin
      act_val    <= value;
      act_dp     <= dp_in;
      act_en     <= digit_en;
      pend_valid <= 1'b0;
    end else if (load) begin
      pend_val   <= value;
      pend_dp    <= dp_in;
      pend_en    <= digit_en;
      pend_valid <= 1'b1;
    end else if (wrap && pend_valid) begin
      act_val    <= pend_val;
      act_dp     <= pend_dp;
      act_en     <= pend_en;
      pend_valid <= 1'b0;
    end
  end

  // Segment/anode generation for the current index
  always_comb begin
    an_next  = '1;
    a2g_next = 7'b1111111;
    dp_next  = 1'b1;
    nibble   = act_val[4*idx +: 4];
    upper    = act_val >> (4 * idx);
    // A digit is a leading zero when it and every higher nibble are zero.
    lz_blank = lz_en && (idx != '0) && (upper == '0);
    if (act_en[idx]) begin
      an_next[idx] = 1'b0;
      dp_next      = ~act_dp[idx];
      if (!lz_blank)
        a2g_next = seg_decode(nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      an         <= '1;
      a2g        <= 7'b1111111;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_next;
      a2g        <= a2g_next;
      dp         <= dp_next;
      frame_tick <= wrap_q;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    digit_en = '0;
  logic          lz_en = 1'b0;
  logic [3:0]    an;
  logic [6:0]    a2g;
  logic          dp;
  logic          frame_tick;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .load(load), .value(value), .dp_in(dp_in),
    .digit_en(digit_en), .lz_en(lz_en), .an(an), .a2g(a2g), .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] a2g;
    logic       dp;
    logic       tick;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  string phase = "reset";

  // Reference model: k = number of clock edges since the reset edge.
  int          k = 0;
  logic [15:0] av = '0, pv = '0;
  logic [3:0]  ad = '0, ae = '0, pd = '0, pe = '0;
  bit          pvld = 0;

  // Drive one cycle of inputs and push what the outputs must be after it.
  task automatic step(input bit rst, input bit ld, input logic [15:0] v,
                      input logic [3:0] d, input logic [3:0] e, input bit lz);
    exp_t x;
    int i;
    logic [15:0] sh;
    @(negedge clk);
    reset = rst; load = ld; value = v; dp_in = d; digit_en = e; lz_en = lz;
    x.tag = phase;
    if (rst) begin
      x.an = 4'b1111; x.a2g = 7'b1111111; x.dp = 1'b1; x.tick = 1'b0;
      k = 0; av = '0; ad = '0; ae = '0; pv = '0; pd = '0; pe = '0; pvld = 0;
    end else begin
      k++;
      i  = ((k - 1) / DIV) % N;
      sh = av >> (4 * i);
      x.tick = (k - 1 > 0) && ((k - 1) % (DIV * N) == 0);
      x.an = 4'b1111; x.a2g = 7'b1111111; x.dp = 1'b1;
      if (ae[i]) begin
        x.an[i] = 1'b0;
        x.dp = ~ad[i];
        if (!(lz && i > 0 && sh == 16'h0)) x.a2g = SEG[sh[3:0]];
      end
      // Frame boundary falls on every N*DIV-th edge.
      if (ld && (k % (DIV * N) == 0)) begin
        av = v; ad = d; ae = e; pvld = 0;
      end else if (ld) begin
        pv = v; pd = d; pe = e; pvld = 1;
      end else if ((k % (DIV * N) == 0) && pvld) begin
        av = pv; ad = pd; ae = pe; pvld = 0;
      end
    end
    q.push_back(x);
  endtask

  task automatic idle(input int n, input bit lz);
    for (int j = 0; j < n; j++) step(0, 0, 16'hDEAD, 4'hF, 4'hF, lz);
  endtask

  // Monitor: compare one expectation per clock edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        checks++;
        if (an !== x.an || a2g !== x.a2g || dp !== x.dp || frame_tick !== x.tick) begin
          errors++;
          $display("FAIL %s @%0t: got an=%b a2g=%b dp=%b tick=%b, want an=%b a2g=%b dp=%b tick=%b",
                   x.tag, $time, an, a2g, dp, frame_tick, x.an, x.a2g, x.dp, x.tick);
        end
      end
    end
  end

  initial begin
    phase = "reset";
    repeat (3) step(1, 0, '0, '0, '0, 0);
    idle(5, 0);

    phase = "scan_zero";
    step(0, 1, 16'h0000, 4'b0000, 4'b1111, 0);
    idle(40, 0);

    phase = "hex_FA9C";
    step(0, 1, 16'hFA9C, 4'b0100, 4'b1111, 0);
    idle(40, 0);

    phase = "lz_0070";
    step(0, 1, 16'h0070, 4'b0000, 4'b1111, 1);
    idle(34, 1);
    phase = "lz_0000";
    step(0, 1, 16'h0000, 4'b0000, 4'b1111, 1);
    idle(34, 1);

    phase = "midframe_load";
    step(0, 1, 16'h1111, 4'b0000, 4'b1111, 0);
    for (int j = 0; j < 40 && ((k / DIV) % N) != 1; j++) idle(1, 0);
    step(0, 1, 16'h2222, 4'b0000, 4'b1111, 0);
    idle(3, 0);
    step(0, 1, 16'h3333, 4'b0001, 4'b1111, 0);
    idle(24, 0);

    phase = "digit_en_1010";
    step(0, 1, 16'h5A5A, 4'b1111, 4'b1010, 0);
    idle(36, 0);

    phase = "reset_midscan";
    step(0, 1, 16'h8888, 4'b0000, 4'b1111, 0);
    idle(20, 0);
    for (int j = 0; j < 40 && (((k - 1) / DIV) % N) != 2; j++) idle(1, 0);
    step(1, 0, '0, '0, '0, 0);
    idle(20, 0);
    step(0, 1, 16'h4321, 4'b0000, 4'b1111, 0);
    idle(20, 0);

    phase = "random";
    for (int j = 0; j < 400; j++)
      step(0, ($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom),
           4'($urandom), 1'($urandom));
    idle(4, 0);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1);
  end
endmodule
